signed_window_minmax: RTL and testbench

- Streaming consumer of signed less-or-equal compare results.
- Accepts a stream of signed two's-complement samples and tracks the running minimum and maximum over a window of WINDOW samples, or fewer if closed early by FLUSH.
- Presents the window result on a valid/ready output, then starts the next window.
- Sits downstream of the signed compare (SLE) datapath in sensor/ALU-side monitoring paths.

---
 rtl/signed_window_minmax.sv | 158 +++++++++++++++
 tb/tb_signed_window_minmax.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/signed_window_minmax.sv
// signed_window_minmax
//   Tracks the signed running minimum and maximum of a sample stream. A window
//   closes after WINDOW accepted samples, or earlier on FLUSH. Its result is
//   then presented on a valid/ready output port. After the handshake the
//   next window starts.
//
// Parameters
//   WIDTH   sample width, signed two's complement
//   WINDOW  samples per window (>= 1)
//
// Ports
//   CLK, RESETN            clock; asynchronous active-low reset
//   I, I_VALID, I_READY    sample input (I_READY high only while accumulating)
//   FLUSH                  close a non-empty window early
//   MIN, MAX, CNT          window result (CNT = samples in the window)
//   O_VALID, O_READY       result handshake
//   MIN_IDX, MAX_IDX       0-based window position of the sample that set
//                          MIN/MAX; present only with
//                          SIGNED_WINDOW_MINMAX_INDEX_EN defined
module signed_window_minmax #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WINDOW = 16
) (
  input  logic                             CLK,
  input  logic                             RESETN,
  input  logic [WIDTH-1:0]                 I,
  input  logic                             I_VALID,
  output logic                             I_READY,
  input  logic                             FLUSH,
  output logic [WIDTH-1:0]                 MIN,
  output logic [WIDTH-1:0]                 MAX,
  output logic [$clog2(WINDOW+1)-1:0]      CNT,
  output logic                             O_VALID,
  input  logic                             O_READY
`ifdef SIGNED_WINDOW_MINMAX_INDEX_EN
  ,
  output logic [((WINDOW > 1) ? $clog2(WINDOW) : 1)-1:0] MIN_IDX,
  output logic [((WINDOW > 1) ? $clog2(WINDOW) : 1)-1:0] MAX_IDX
`endif
);

  localparam int unsigned CW = $clog2(WINDOW + 1);
  localparam int unsigned IW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             o_valid_q, o_valid_d;
  logic             accept;
  logic             close_win;
`ifdef SIGNED_WINDOW_MINMAX_INDEX_EN
  logic [IW-1:0]    min_idx_q, min_idx_d;
  logic [IW-1:0]    max_idx_q, max_idx_d;
`endif

  assign I_READY = (state_q == ACCUM);
  assign accept  = I_VALID && I_READY;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    min_d     = min_q;
    max_d     = max_q;
    cnt_d     = cnt_q;
    o_valid_d = o_valid_q;
    close_win = 1'b0;
`ifdef SIGNED_WINDOW_MINMAX_INDEX_EN
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;
`endif

    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          // Ties replace (<=), so the latest equal sample owns the extreme.
          if (count_q == '0 || $signed(I) <= $signed(min_q)) begin
            min_d = I;
`ifdef SIGNED_WINDOW_MINMAX_INDEX_EN
            min_idx_d = IW'(count_q);
`endif
          end
          if (count_q == '0 || $signed(max_q) <= $signed(I)) begin
            max_d = I;
`ifdef SIGNED_WINDOW_MINMAX_INDEX_EN
            max_idx_d = IW'(count_q);
`endif
          end
          count_d = count_q + 1'b1;
        end
        // An empty window is never emitted: FLUSH needs a sample already
        // held or one arriving on the same edge.
        close_win = (accept && (count_q == CW'(WINDOW - 1))) ||
                    (FLUSH && ((count_q != '0) || accept));
        if (close_win) begin
          state_d   = HOLD;
          cnt_d     = count_d;
          o_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (o_valid_q && O_READY) begin
          o_valid_d = 1'b0;
          count_d   = '0;
          state_d   = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= ACCUM;
      count_q   <= '0;
      min_q     <= '0;
      max_q     <= '0;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      min_q     <= min_d;
      max_q     <= max_d;
      cnt_q     <= cnt_d;
      o_valid_q <= o_valid_d;
    end
  end

`ifdef SIGNED_WINDOW_MINMAX_INDEX_EN
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      min_idx_q <= '0;
      max_idx_q <= '0;
    end else begin
      min_idx_q <= min_idx_d;
      max_idx_q <= max_idx_d;
    end
  end

  assign MIN_IDX = min_idx_q;
  assign MAX_IDX = max_idx_q;
`else
  // Position tracking is not built in this configuration.
`endif

  assign MIN     = min_q;
  assign MAX     = max_q;
  assign CNT     = cnt_q;
  assign O_VALID = o_valid_q;

endmodule

// File: tb/tb_signed_window_minmax.sv
module tb_signed_window_minmax;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned WINDOW = 4;
  localparam int unsigned CW     = $clog2(WINDOW + 1);
  localparam int unsigned IW     = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic             CLK = 1'b0;
  logic             RESETN;
  logic [WIDTH-1:0] I;
  logic             I_VALID;
  logic             I_READY;
  logic             FLUSH;
  logic [WIDTH-1:0] MIN;
  logic [WIDTH-1:0] MAX;
  logic [CW-1:0]    CNT;
  logic             O_VALID;
  logic             O_READY;
`ifdef SIGNED_WINDOW_MINMAX_INDEX_EN
  logic [IW-1:0]    MIN_IDX;
  logic [IW-1:0]    MAX_IDX;
`endif

  int compared   = 0;
  int mismatched = 0;

  signed_window_minmax #(
    .WIDTH  (WIDTH),
    .WINDOW (WINDOW)
  ) dut (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .I       (I),
    .I_VALID (I_VALID),
    .I_READY (I_READY),
    .FLUSH   (FLUSH),
    .MIN     (MIN),
    .MAX     (MAX),
    .CNT     (CNT),
    .O_VALID (O_VALID),
    .O_READY (O_READY)
`ifdef SIGNED_WINDOW_MINMAX_INDEX_EN
    ,
    .MIN_IDX (MIN_IDX),
    .MAX_IDX (MAX_IDX)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit before sampling or re-driving.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [7:0] mn, input logic [7:0] mx,
                              input int cnt);
    check({tag, ".o_valid"}, 32'(O_VALID), 32'd1);
    check({tag, ".min"},     32'(MIN),     32'(mn));
    check({tag, ".max"},     32'(MAX),     32'(mx));
    check({tag, ".cnt"},     32'(CNT),     32'(cnt));
    check({tag, ".i_ready"}, 32'(I_READY), 32'd0);
  endtask

  task automatic handshake();
    I_VALID = 1'b0;
    FLUSH   = 1'b0;
    O_READY = 1'b1;
    step();
    O_READY = 1'b0;
  endtask

  initial begin
    RESETN  = 1'b0;
    I       = '0;
    I_VALID = 1'b0;
    FLUSH   = 1'b0;
    O_READY = 1'b0;
    #1;
    check("rst.i_ready", 32'(I_READY), 32'd1);
    step();
    check("rst.o_valid", 32'(O_VALID), 32'd0);
    check("rst.min",     32'(MIN),     32'd0);
    check("rst.max",     32'(MAX),     32'd0);
    check("rst.cnt",     32'(CNT),     32'd0);
`ifdef SIGNED_WINDOW_MINMAX_INDEX_EN
    check("rst.min_idx", 32'(MIN_IDX), 32'd0);
    check("rst.max_idx", 32'(MAX_IDX), 32'd0);
`endif
    RESETN = 1'b1;
    step();

    // Full window with signed extremes.
    I_VALID = 1'b1;
    I = 8'h05; step();
    I = 8'hFD; step();
    I = 8'h7F; step();
    I = 8'h80; step();
    check_result("win1", 8'h80, 8'h7F, 4);
`ifdef SIGNED_WINDOW_MINMAX_INDEX_EN
    check("win1.min_idx", 32'(MIN_IDX), 32'd3);
    check("win1.max_idx", 32'(MAX_IDX), 32'd2);
`endif

    // Back-pressure: result held, offered sample not taken.
    I = 8'h11;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp.hold", {O_VALID, I_READY, CNT, MIN, MAX}, {1'b1, 1'b0, CW'(4), 8'h80, 8'h7F});
    end
    O_READY = 1'b1;
    step();
    check("bp.o_valid_drop", 32'(O_VALID), 32'd0);
    check("bp.i_ready",      32'(I_READY), 32'd1);
    check("bp.min_kept",     32'(MIN),     32'h80);
    O_READY = 1'b0;
    step();
    check("bp.first.min", 32'(MIN), 32'h11);
    check("bp.first.max", 32'(MAX), 32'h11);
    // Close a single-sample window with FLUSH alone.
    I_VALID = 1'b0;
    FLUSH   = 1'b1;
    step();
    check_result("one", 8'h11, 8'h11, 1);
    handshake();

    // Ties: latest equal sample wins.
    I_VALID = 1'b1;
    I = 8'h07;
    for (int k = 0; k < 4; k++) step();
    check_result("tie", 8'h07, 8'h07, 4);
`ifdef SIGNED_WINDOW_MINMAX_INDEX_EN
    check("tie.min_idx", 32'(MIN_IDX), 32'd3);
    check("tie.max_idx", 32'(MAX_IDX), 32'd3);
`endif
    handshake();

    // Early flush after two samples.
    I_VALID = 1'b1;
    I = 8'hFF; step();
    I = 8'h00; step();
    I_VALID = 1'b0;
    FLUSH   = 1'b1;
    step();
    check_result("flush2", 8'hFF, 8'h00, 2);
`ifdef SIGNED_WINDOW_MINMAX_INDEX_EN
    check("flush2.min_idx", 32'(MIN_IDX), 32'd0);
    check("flush2.max_idx", 32'(MAX_IDX), 32'd1);
`endif
    handshake();

    // Flush of an empty window is ignored.
    FLUSH = 1'b1;
    step();
    step();
    check("flush0.o_valid", 32'(O_VALID), 32'd0);
    check("flush0.i_ready", 32'(I_READY), 32'd1);
    FLUSH = 1'b0;

    // Asynchronous reset mid-window.
    I_VALID = 1'b1;
    I = 8'h10; step();
    I = 8'h20; step();
    I_VALID = 1'b0;
    #2 RESETN = 1'b0;
    #1;
    check("rstmid.o_valid", 32'(O_VALID), 32'd0);
    check("rstmid.min",     32'(MIN),     32'd0);
    check("rstmid.max",     32'(MAX),     32'd0);
    #1 RESETN = 1'b1;
    step();
    I_VALID = 1'b1;
    I = 8'h01; step();
    I = 8'h02; step();
    I = 8'h03; step();
    I = 8'h04; step();
    I_VALID = 1'b0;
    check_result("after_rst", 8'h01, 8'h04, 4);

    // Asynchronous reset while a result is held.
    #2 RESETN = 1'b0;
    #1;
    check("rsthold.o_valid", 32'(O_VALID), 32'd0);
    check("rsthold.cnt",     32'(CNT),     32'd0);
    check("rsthold.i_ready", 32'(I_READY), 32'd1);
    #1 RESETN = 1'b1;
    step();

    // Sample accepted on the FLUSH edge is included.
    I_VALID = 1'b1;
    I = 8'h02; step();
    I = 8'h06; step();
    I = 8'hF7;
    FLUSH = 1'b1;
    step();
    I_VALID = 1'b0;
    FLUSH   = 1'b0;
    check_result("flush_acc", 8'hF7, 8'h06, 3);
`ifdef SIGNED_WINDOW_MINMAX_INDEX_EN
    check("flush_acc.min_idx", 32'(MIN_IDX), 32'd2);
    check("flush_acc.max_idx", 32'(MAX_IDX), 32'd1);
`endif
    handshake();
    check("final.o_valid", 32'(O_VALID), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
